// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU between NUM_REQ requesters,
// with the tagged result returned over a valid/ready channel.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [18*NUM_REQ-1:0]   req_instr_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [1:0]              alu_op_o,
  output logic [7:0]              alu_a_o,
  output logic [7:0]              alu_b_o,
  input  logic [15:0]             alu_result_i,
  input  logic                    alu_neg_i,
  output logic                    rsp_valid_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [15:0]             rsp_result_o,
  output logic                    rsp_neg_o,
  input  logic                    rsp_ready_i,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam logic [ID_W:0]   NR   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ-1);
  state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d, gnt;
  logic [ID_W:0] idx;
  logic [17:0] instr_q, instr_d;
  logic [15:0] result_q, result_d;
  logic neg_q, neg_d, found, take;
  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      idx = idx >= NR ? idx - NR : idx;
      if (req_valid_i[idx[ID_W-1:0]]) begin
        gnt = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (found ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (rsp_ready_i ? IDLE : RESP);
  always_comb begin
    take = rst_n && state_q == IDLE && found;
    req_ready_o = take ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt : '0;
    busy_o = state_q != IDLE;
    rsp_valid_o = state_q == RESP;
  end
  always_comb begin
    instr_d  = take ? req_instr_i[18*gnt +: 18] : instr_q;
    rsp_id_d = take ? gnt : rsp_id_q;
    rr_ptr_d = take ? (gnt == LAST ? '0 : gnt + 1'b1) : rr_ptr_q;
    result_d = state_q == EXEC ? alu_result_i : result_q;
    neg_d    = state_q == EXEC ? alu_neg_i : neg_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_q  <= '0;
      rsp_id_q <= '0;
      rr_ptr_q <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      rsp_id_q <= rsp_id_d;
      rr_ptr_q <= rr_ptr_d;
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  assign {alu_op_o, alu_a_o, alu_b_o} = instr_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = result_q;
  assign rsp_neg_o    = neg_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: scoreboard bench; grants predicted by a round-robin reference,
// responses popped and compared whenever the DUT presents one.
module tb_alu_rr_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [71:0] req_instr = '0;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [15:0] alu_result, rsp_result;
  logic alu_neg, rsp_valid, rsp_neg, busy;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;

  alu_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_instr_i(req_instr),
    .req_ready_o(req_ready), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_neg_i(alu_neg), .rsp_valid_o(rsp_valid),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .rsp_neg_o(rsp_neg),
    .rsp_ready_i(rsp_ready), .busy_o(busy));

  assign alu_result = {alu_a, alu_b};
  assign alu_neg = alu_op[1];
  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] id; logic [17:0] instr;} exp_t;
  exp_t sb[$];
  int glog[$];
  int total = 0, bad = 0, cyc = 0, ptr_m = 0, gcount = 0, grant_cyc = 0, grant_id = 0;
  bit pending = 0, grant_now = 0, resp_now = 0;
  logic [3:0] acc_mask = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) begin
      int i = (p + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Issue side: predict the grant and push the expected response.
  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    exp_t e;
    grant_now = 0;
    acc_mask = '0;
    if (rst_n) begin
      g = pending ? -1 : pick(req_valid, ptr_m);
      er = g < 0 ? 4'b0 : 4'b1 << g;
      chk("busy", 32'(busy), 32'(pending));
      chk("req_ready", 32'(req_ready), 32'(er));
      if (g >= 0) begin
        e.id = 2'(g);
        e.instr = req_instr[g*18 +: 18];
        sb.push_back(e);
        grant_now = 1;
        grant_id = g;
        grant_cyc = cyc;
        acc_mask = er;
        glog.push_back(g);
      end
    end
  end

  // Response side: compare against the oldest outstanding entry.
  always @(negedge clk) begin
    bit ev;
    resp_now = 0;
    if (rst_n) begin
      ev = pending && (cyc - grant_cyc >= 2);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (pending && sb.size() > 0) chk("alu_in", 32'({alu_op, alu_a, alu_b}), 32'(sb[0].instr));
      if (ev && rsp_valid && sb.size() > 0) begin
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("rsp_result", 32'(rsp_result), 32'(sb[0].instr[15:0]));
        chk("rsp_neg", 32'(rsp_neg), 32'(sb[0].instr[17]));
        if (rsp_ready) begin
          void'(sb.pop_front());
          resp_now = 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= 0;
      ptr_m <= 0;
      sb.delete();
    end else begin
      cyc <= cyc + 1;
      if (grant_now) begin
        pending <= 1;
        ptr_m <= (grant_id + 1) % 4;
        gcount <= gcount + 1;
      end else if (resp_now) pending <= 0;
    end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(int n, int budget);
    int start = gcount, c = 0;
    while (gcount - start < n && c < budget) begin step(1); c++; end
    if (gcount - start < n) begin
      total++; bad++;
      $display("FAIL grant_timeout: got %0d grants want %0d", gcount - start, n);
    end
  endtask

  task automatic wait_idle(int budget);
    int c = 0;
    while ((pending || sb.size() > 0) && c < budget) begin step(1); c++; end
    if (pending || sb.size() > 0) begin
      total++; bad++;
      $display("FAIL idle_timeout: got pending=%0d want 0", pending);
    end
  endtask

  initial begin
    int g0;
    req_valid = 4'b1111;
    step(2);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_alu", 32'({alu_op, alu_a, alu_b}), 0);
    chk("rst_rsp", 32'({rsp_id, rsp_result, rsp_neg}), 0);
    req_valid = '0;
    rst_n = 1'b1;
    step(1);
    // all requesters valid: grants rotate from 0
    for (int i = 0; i < 4; i++) req_instr[i*18 +: 18] = 18'($urandom);
    glog.delete();
    req_valid = 4'b1111;
    wait_grants(5, 60);
    req_valid = '0;
    wait_idle(20);
    for (int i = 0; i < 5; i++) chk("order", glog.size() > i ? 32'(glog[i]) : 32'hFF, 32'(i % 4));
    // single request
    glog.delete();
    req_instr[18 +: 18] = {2'b10, 8'h05, 8'h03};
    req_valid = 4'b0010;
    wait_grants(1, 20);
    req_valid = '0;
    wait_idle(20);
    chk("single_id", glog.size() > 0 ? 32'(glog[0]) : 32'hFF, 1);
    // backpressure: no grants while the response is stalled
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    wait_grants(1, 20);
    req_valid = 4'b1111;
    step(2);
    g0 = gcount;
    step(5);
    chk("bp_no_grant", 32'(gcount), 32'(g0));
    chk("bp_busy", 32'(busy), 1);
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    glog.delete();
    wait_grants(1, 4);
    req_valid = '0;
    wait_idle(20);
    // pointer wrap from 3 back to 0
    req_valid = 4'b1000;
    wait_grants(1, 20);
    req_valid = 4'b1001;
    glog.delete();
    wait_grants(2, 30);
    req_valid = '0;
    wait_idle(20);
    chk("wrap0", glog.size() > 0 ? 32'(glog[0]) : 32'hFF, 0);
    chk("wrap1", glog.size() > 1 ? 32'(glog[1]) : 32'hFF, 3);
    // asynchronous reset while in EXEC
    req_valid = 4'b0110;
    wait_grants(1, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    glog.delete();
    #10 rst_n = 1'b1;
    wait_grants(1, 20);
    req_valid = '0;
    wait_idle(20);
    chk("post_rst_grant", glog.size() > 0 ? 32'(glog[0]) : 32'hFF, 1);
    // idle: pointer must stay at 2
    step(10);
    glog.delete();
    req_valid = 4'b1111;
    wait_grants(1, 20);
    req_valid = '0;
    wait_idle(20);
    chk("idle_ptr", glog.size() > 0 ? 32'(glog[0]) : 32'hFF, 2);
    // random traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      rsp_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < 4; i++)
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            req_instr[i*18 +: 18] = 18'($urandom);
          end
        end else if (acc_mask[i] || $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      step(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
